// File: rtl/countdown_timer_pkg.sv
// Shared types for the MM:SS countdown timer: state encoding, BCD digit/byte types.
package countdown_timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } state_t;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    digit_t tens;
    digit_t ones;
  } bcd_t;

  function automatic int bcdToInt(bcd_t b);
    return int'(b.tens) * 10 + int'(b.ones);
  endfunction

  function automatic logic bcdLegal(bcd_t b, digit_t tensMax);
    return (b.ones <= 4'd9) && (b.tens <= tensMax);
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// One decrementing BCD digit: wraps 0 -> WRAP and raises borrowO when borrowed from at zero.
module bcd_digit
  import countdown_timer_pkg::*;
#(
  parameter digit_t WRAP = 4'd9
) (
  input  digit_t digitI,
  input  logic   borrowI,
  output digit_t digitO,
  output logic   borrowO
);

  always_comb begin
    digitO  = digitI;
    borrowO = 1'b0;
    if (borrowI) begin
      if (digitI == 4'd0) begin
        digitO  = WRAP;
        borrowO = 1'b1;
      end else begin
        digitO = digitI - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer clocked by rising edges of the divider's tick level.
// Optional alarm square wave after expiry: define COUNTDOWN_ALARM_EN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int MAX_MIN     = 59,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clkI,
  input  logic       rstI,
  input  logic       tickI,
  input  logic       clearI,
  input  logic       loadI,
  input  logic [7:0] minI,
  input  logic [7:0] secI,
  input  logic       startI,
  input  logic       pauseI,
  output logic [7:0] minO,
  output logic [7:0] secO,
  output logic [1:0] stateO,
  output logic       doneO,
  output logic       alarmO
);

  if (MAX_MIN > 99 || MAX_MIN < 0) begin : gBadMaxMin
    $error("MAX_MIN must be within 0..99");
  end
  if (ALARM_TICKS < 1) begin : gBadAlarmTicks
    $error("ALARM_TICKS must be at least 1");
  end

  state_t state, stateN;
  bcd_t   minR, secR, minN, secN;
  logic   doneR, doneN;
  logic   tickHist;

  logic [3:0][3:0] curDig, decDig;
  logic [4:0]      borrow;
  logic            tickEdge, decZero, valNz, loadAcc;

  // digit 0 = seconds ones ... digit 3 = minutes tens; seconds tens wraps to 5
  assign curDig    = {minR, secR};
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < 4; g++) begin : gDig
    bcd_digit #(.WRAP((g == 1) ? 4'd5 : 4'd9)) uDig (
      .digitI (curDig[g]),
      .borrowI(borrow[g]),
      .digitO (decDig[g]),
      .borrowO(borrow[g+1])
    );
  end

  assign tickEdge = tickI & ~tickHist;
  assign decZero  = (decDig == '0);
  assign valNz    = |curDig;
  assign loadAcc  = loadI && (state != RUN)
                 && bcdLegal(bcd_t'(secI), 4'd5) && bcdLegal(bcd_t'(minI), 4'd9)
                 && (bcdToInt(bcd_t'(minI)) <= MAX_MIN);

  always_comb begin
    stateN = state;
    minN   = minR;
    secN   = secR;
    doneN  = 1'b0;
    if (clearI) begin
      minN   = '0;
      secN   = '0;
      stateN = IDLE;
    end else if (loadAcc) begin
      minN   = bcd_t'(minI);
      secN   = bcd_t'(secI);
      stateN = IDLE;
    end else begin
      // a rejected/ignored load still outranks start and pause
      if (!loadI) begin
        if (startI) begin
          if ((state == IDLE || state == PAUSE) && valNz) stateN = RUN;
        end else if (pauseI && state == RUN) begin
          stateN = PAUSE;
        end
      end
      // the decrement lands even when pause arrives with it; expiry beats pause
      if (tickEdge && state == RUN && !borrow[4]) begin
        {minN, secN} = decDig;
        if (decZero) begin
          stateN = DONE;
          doneN  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      state    <= IDLE;
      minR     <= '0;
      secR     <= '0;
      doneR    <= 1'b0;
      tickHist <= 1'b1;
    end else begin
      state    <= stateN;
      minR     <= minN;
      secR     <= secN;
      doneR    <= doneN;
      tickHist <= tickI;
    end
  end

  assign minO   = minR;
  assign secO   = secR;
  assign stateO = state;
  assign doneO  = doneR;

`ifdef COUNTDOWN_ALARM_EN
  localparam int CNT_W = $clog2(ALARM_TICKS + 1);

  logic             alarmR, alarmN, alarmClr, doneEdge;
  logic [CNT_W-1:0] alarmCnt, cntN;

  assign alarmClr = clearI | loadAcc;
  assign doneEdge = tickEdge && (state == DONE);

  always_comb begin
    alarmN = alarmR;
    cntN   = alarmCnt;
    if (alarmClr) begin
      alarmN = 1'b0;
      cntN   = '0;
    end else if (doneN) begin
      alarmN = 1'b1;
      cntN   = CNT_W'(ALARM_TICKS);
    end else if (doneEdge && alarmCnt != '0) begin
      cntN   = alarmCnt - 1'b1;
      alarmN = (alarmCnt == CNT_W'(1)) ? 1'b0 : ~alarmR;
    end
  end

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      alarmR   <= 1'b0;
      alarmCnt <= '0;
    end else begin
      alarmR   <= alarmN;
      alarmCnt <= cntN;
    end
  end

  assign alarmO = alarmR;
`else
  assign alarmO = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed + random bench for countdown_timer against a total-seconds reference model.
module tb_countdown_timer;

  localparam int MAX_MIN     = 59;
  localparam int ALARM_TICKS = 4;

  logic       clkI = 1'b0, rstI = 1'b1, tickI = 1'b1;
  logic       clearI = 1'b0, loadI = 1'b0, startI = 1'b0, pauseI = 1'b0;
  logic [7:0] minI = 8'h00, secI = 8'h00;
  logic [7:0] minO, secO;
  logic [1:0] stateO;
  logic       doneO, alarmO;

  int nAsserts = 0, nFails = 0;

  // reference model: remaining time in whole seconds, state as 0..3
  int mTot, mSt, mCnt;
  bit mDone, mAlarm, mHist;

  countdown_timer #(.MAX_MIN(MAX_MIN), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clkI(clkI), .rstI(rstI), .tickI(tickI), .clearI(clearI), .loadI(loadI),
    .minI(minI), .secI(secI), .startI(startI), .pauseI(pauseI),
    .minO(minO), .secO(secO), .stateO(stateO), .doneO(doneO), .alarmO(alarmO)
  );

  always #5 clkI = ~clkI;

  function automatic logic [7:0] toBcd(int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic bit loadLegal(logic [7:0] m, logic [7:0] s);
    int mt, mo, st, so;
    mt = int'(m[7:4]); mo = int'(m[3:0]); st = int'(s[7:4]); so = int'(s[3:0]);
    return mo <= 9 && mt <= 9 && so <= 9 && st <= 5 && (mt * 10 + mo) <= MAX_MIN;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mTot = 0; mSt = 0; mCnt = 0; mDone = 0; mAlarm = 0; mHist = 1;
  endtask

  task automatic modelStep();
    bit edgeSeen, ldOk;
    int st0;
    edgeSeen = tickI && !mHist;
    mHist    = tickI;
    st0      = mSt;
    mDone    = 0;
    ldOk     = loadI && st0 != 1 && loadLegal(minI, secI);
    if (clearI) begin
      mTot = 0; mSt = 0; mAlarm = 0; mCnt = 0;
    end else if (ldOk) begin
      mTot = int'(minI[7:4]) * 600 + int'(minI[3:0]) * 60 + int'(secI[7:4]) * 10 + int'(secI[3:0]);
      mSt = 0; mAlarm = 0; mCnt = 0;
    end else begin
      if (!loadI) begin
        if (startI) begin
          if ((st0 == 0 || st0 == 2) && mTot != 0) mSt = 1;
        end else if (pauseI && st0 == 1) mSt = 2;
      end
      if (edgeSeen && st0 == 1) begin
        mTot--;
        if (mTot == 0) begin
          mSt = 3; mDone = 1;
`ifdef COUNTDOWN_ALARM_EN
          mAlarm = 1; mCnt = ALARM_TICKS;
`endif
        end
      end else if (edgeSeen && st0 == 3 && mCnt > 0) begin
        mCnt--;
        mAlarm = (mCnt == 0) ? 1'b0 : !mAlarm;
      end
    end
  endtask

  task automatic checkAll(string ctx);
    chk({ctx, ".min"},   16'(minO),   16'(toBcd(mTot / 60)));
    chk({ctx, ".sec"},   16'(secO),   16'(toBcd(mTot % 60)));
    chk({ctx, ".state"}, 16'(stateO), 16'(mSt));
    chk({ctx, ".done"},  16'(doneO),  16'(mDone));
    chk({ctx, ".alarm"}, 16'(alarmO), 16'(mAlarm));
  endtask

  task automatic cycle(string ctx);
    @(posedge clkI);
    modelStep();
    #1;
    checkAll(ctx);
  endtask

  task automatic cmd(string ctx, bit c, bit l, logic [7:0] m, logic [7:0] s, bit st, bit p);
    clearI = c; loadI = l; minI = m; secI = s; startI = st; pauseI = p;
    cycle(ctx);
    clearI = 0; loadI = 0; startI = 0; pauseI = 0;
  endtask

  task automatic tick(string ctx);
    tickI = 1; cycle(ctx);
    tickI = 0; cycle(ctx);
  endtask

  initial begin
    modelReset();
    // reset held with tick high
    repeat (3) @(posedge clkI);
    #1 checkAll("rst");
    @(negedge clkI) rstI = 0;
    repeat (3) cycle("rel");
    chk("relState", 16'(stateO), 16'h0);
    tickI = 0; cycle("rel0");

    // 01:00 down to expiry
    cmd("ld0100", 0, 1, 8'h01, 8'h00, 0, 0);
    cmd("st0100", 0, 0, 8'h00, 8'h00, 1, 0);
    tick("t1");
    chk("t1min", 16'(minO), 16'h00);
    chk("t1sec", 16'(secO), 16'h59);
    repeat (58) tick("cnt");
    tickI = 1; cycle("last");
    chk("doneHi", 16'(doneO), 16'h1);
    chk("doneSt", 16'(stateO), 16'h3);
    tickI = 0; cycle("after");
    chk("doneLo", 16'(doneO), 16'h0);

    // double borrow, rejected loads
    cmd("ld1000", 0, 1, 8'h10, 8'h00, 0, 0);
    cmd("st1000", 0, 0, 8'h00, 8'h00, 1, 0);
    tick("dbl");
    chk("dblMin", 16'(minO), 16'h09);
    chk("dblSec", 16'(secO), 16'h59);
    cmd("pz", 0, 0, 8'h00, 8'h00, 0, 1);
    cmd("ld005A", 0, 1, 8'h00, 8'h5A, 0, 0);
    chk("rejSec", 16'(secO), 16'h59);
    cmd("ld6000", 0, 1, 8'h60, 8'h00, 0, 0);
    chk("rejMin", 16'(minO), 16'h09);
    cmd("ld0070", 0, 1, 8'h00, 8'h70, 0, 0);

    // pause coincident with tick edge
    cmd("ld0005", 0, 1, 8'h00, 8'h05, 0, 0);
    cmd("st0005", 0, 0, 8'h00, 8'h00, 1, 0);
    tickI = 1; pauseI = 1; cycle("pzTick");
    pauseI = 0;
    chk("pzSec", 16'(secO), 16'h04);
    chk("pzSt", 16'(stateO), 16'h2);
    tickI = 0; cycle("pz0");
    repeat (2) tick("pzHold");
    chk("pzHeld", 16'(secO), 16'h04);
    cmd("resume", 0, 0, 8'h00, 8'h00, 1, 0);
    chk("resSt", 16'(stateO), 16'h1);

    // clear beats start; start at zero ignored
    cmd("pz2", 0, 0, 8'h00, 8'h00, 0, 1);
    cmd("ld0300", 0, 1, 8'h03, 8'h00, 0, 0);
    cmd("st0300", 0, 0, 8'h00, 8'h00, 1, 0);
    cmd("pz3", 0, 0, 8'h00, 8'h00, 0, 1);
    cmd("clrSt", 1, 0, 8'h00, 8'h00, 1, 0);
    chk("clrSt", 16'(stateO), 16'h0);
    chk("clrMin", 16'(minO), 16'h00);
    cmd("stZero", 0, 0, 8'h00, 8'h00, 1, 0);
    chk("stZero", 16'(stateO), 16'h0);

    // expiry and alarm
    cmd("ld0002", 0, 1, 8'h00, 8'h02, 0, 0);
    cmd("st0002", 0, 0, 8'h00, 8'h02, 1, 0);
    repeat (2) tick("alm");
`ifdef COUNTDOWN_ALARM_EN
    chk("almOn", 16'(alarmO), 16'h1);
    tick("a1"); chk("alm1", 16'(alarmO), 16'h0);
    tick("a2"); chk("alm2", 16'(alarmO), 16'h1);
    tick("a3"); chk("alm3", 16'(alarmO), 16'h0);
    tick("a4"); chk("alm4", 16'(alarmO), 16'h0);
    tick("a5"); chk("alm5", 16'(alarmO), 16'h0);
`else
    repeat (5) tick("almOff");
    chk("almOff", 16'(alarmO), 16'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int mm, ss;
      tickI  = 1'($urandom_range(0, 1));
      clearI = ($urandom_range(0, 99) < 2);
      loadI  = ($urandom_range(0, 99) < 6);
      startI = ($urandom_range(0, 99) < 12);
      pauseI = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) != 0) begin
        mm   = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 65) : $urandom_range(0, 1);
        ss   = $urandom_range(0, 59);
        minI = toBcd(mm);
        secI = toBcd(ss);
      end else begin
        minI = 8'($urandom);
        secI = 8'($urandom);
      end
      cycle("rnd");
    end
    clearI = 0; loadI = 0; startI = 0; pauseI = 0; tickI = 0;
    cycle("rndEnd");

    // asynchronous reset mid-count
    cmd("clrR", 1, 0, 8'h00, 8'h00, 0, 0);
    cmd("ld0030", 0, 1, 8'h00, 8'h30, 0, 0);
    cmd("st0030", 0, 0, 8'h00, 8'h00, 1, 0);
    repeat (2) tick("pre");
    @(negedge clkI); #2 rstI = 1;
    modelReset();
    #1 checkAll("async");
    repeat (2) @(posedge clkI);
    #1 checkAll("held");
    @(negedge clkI) rstI = 0;
    repeat (2) cycle("post");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

- BCD minutes:seconds countdown timer, directly downstream of the clock divider.
- Consumes the divider's slow square-wave output as `tickI`, detects its rising edges in the fast clock domain, and decrements a loaded MM:SS value once per edge.
- Provides a done pulse and an optional alarm output for the display/buzzer stage.

## Interface
- `MAX_MIN`, 59 — largest loadable minute value (decimal, ≤ 99).
- `ALARM_TICKS`, 10 — number of tick edges the alarm toggles after expiry.

- `clkI` in 1 — system clock; same clock that drives the divider.
- `rstI` in 1 — reset: asynchronous, active-high.
- `tickI` in 1 — divider output level, synchronous to `clkI`.
- `clearI` in 1 — one-cycle pulse: zero value, go IDLE.
- `loadI` in 1 — one-cycle pulse: load `minI`/`secI`.
- `minI` in 8 — load minutes, two BCD digits.
- `secI` in 8 — load seconds, two BCD digits.
- `startI` in 1 — one-cycle pulse: begin/resume counting.
- `pauseI` in 1 — one-cycle pulse: suspend counting.
- `minO` out 8 — current minutes, BCD.
- `secO` out 8 — current seconds, BCD.
- `stateO` out 2 — IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `doneO` out 1 — one-cycle pulse on expiry.
- `alarmO` out 1 — alarm square wave (see Configuration).

## Operation
- **Reset values:** `minO=0x00`, `secO=0x00`, `stateO=IDLE`, `doneO=0`, `alarmO=0`, alarm counter 0.
- **Edge-history register:** resets to 1, so a high `tickI` at reset release is not an edge.
- **Tick edge:** `tickI==1` and edge-history `==0`.
  - Edge-history tracks `tickI` every cycle in all states.
  - Edges outside RUN/DONE are discarded.
- **Command priority:** `clearI` > `loadI` > `startI` > `pauseI`. Only the highest asserted command acts.
- **clearI:** value := 00:00, state := IDLE, `alarmO` := 0. Valid from any state.
- **loadI:**
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Rejected (no change) if any digit > 9, seconds tens > 5, or minutes > `MAX_MIN`.
  - Accepted load: state := IDLE, `alarmO` := 0.
- **startI:** in IDLE or PAUSE with value ≠ 00:00 → RUN. Ignored if value is 00:00, or in RUN or DONE.
- **pauseI:** in RUN → PAUSE; ignored elsewhere.
- **RUN, on each tick edge:**
  - Decrement by one second.
  - Seconds ones 0 → 9 with borrow; seconds tens 0 → 5 with minute borrow; minutes ones 0 → 9 with tens borrow.
  - Decrement that reaches 00:00: state := DONE and `doneO`=1 in that same update.
- **Tick edge and `pauseI` in the same cycle in RUN:** decrement applies, then state := PAUSE.
  - If that decrement reaches 00:00, DONE wins over PAUSE.
- **DONE:** value holds at 00:00 until `clearI` or `loadI`.

## Timing
- Tick edge detected at clock edge k → new `minO`/`secO` visible after edge k (1-cycle latency from `tickI` rise).
- Command pulse sampled at edge k → state/value change visible after edge k.
- `doneO` high for exactly one cycle, the cycle after the final decrement's clock edge.
- `rstI` mid-count: immediate asynchronous return to reset values; no `doneO`.
- Consecutive tick edges need ≥ 2 `clkI` cycles between them; guaranteed by divider `M` ≥ 2.

## Configuration
- **`COUNTDOWN_ALARM_EN` defined:**
  - On entering DONE, `alarmO` := 1 and the alarm counter := `ALARM_TICKS`.
  - Each subsequent tick edge in DONE toggles `alarmO` and decrements the counter.
  - When the counter reaches 0, `alarmO` := 0 and is held there.
- **Not defined:** `alarmO` tied to 0, no alarm counter, `ALARM_TICKS` unused.

## Structure
- **Shared package:**
  - state enum (IDLE/RUN/PAUSE/DONE, 2 bits)
  - BCD byte typedef (two 4-bit digits)
  - state encoding constants for `stateO`
- **Sub-module `bcd_digit`:** one decrementing BCD digit with parameterised wrap value (9 or 5), borrow-in and borrow-out.
  - Instantiated four times: seconds ones, seconds tens, minutes ones, minutes tens.

## Test plan
- Reset with `tickI=1` held, release → no decrement, all outputs 0, state IDLE.
- Load 01:00, start, 1 tick edge → 00:59; 59 more edges → 00:00, `doneO` single-cycle pulse, state DONE.
- Load 10:00, start, 1 edge → 09:59 (double borrow). Load 00:5A → rejected. Load 60:00 with `MAX_MIN`=59 → rejected.
- RUN at 00:05, `pauseI` coincident with tick edge → 00:04 and PAUSE; further edges → no change; `startI` → RUN.
- Same cycle `clearI` + `startI` at 03:00 in PAUSE → 00:00 IDLE. Start at 00:00 → stays IDLE.
- With `COUNTDOWN_ALARM_EN`, `ALARM_TICKS`=4: expiry → `alarmO`=1, toggles 1,0,1,0 across 4 edges, then 0. Without the macro: `alarmO`=0 throughout.
